// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 8-bit, 4-register pipelined core.
// Produces stall/flush/bubble controls for the IF/PC, IF/ID and ID/EX stages,
// handles load-use hazards and taken branches resolved in EX, and runs the
// interrupt-entry sequence (drain the pipe, then inject a vector CALL into ID).
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,   // 1..15 cycles of IF freeze before injection
    parameter int CNT_W        = 16   // width of the saturating stall counter
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       id_ra,
    input  logic [1:0]       id_rb,
    input  logic             id_uses_ra,
    input  logic             id_uses_rb,
    input  logic             ex_mem_read,
    input  logic [1:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             irq,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             id_ex_bubble,
    output logic             int_inject,
    output logic             irq_ack,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ENTER = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t           state_reg, state_next;
    logic             irq_pend_reg, irq_pend_next;
    logic             irq_q_reg;
    logic [3:0]       drain_cnt_reg, drain_cnt_next;
    logic             irq_ack_reg, irq_ack_next;
    logic [CNT_W-1:0] stall_count_reg;

    logic luh;
    logic irq_rise;

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    assign luh = ex_mem_read &
                 ((id_uses_ra & (id_ra == ex_rd)) | (id_uses_rb & (id_rb == ex_rd)));

    assign irq_rise = irq & ~irq_q_reg;

    // Control outputs: FSM baseline, overridden by load-use, overridden by branch.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        int_inject   = 1'b0;

        case (state_reg)
            DRAIN: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                if_id_flush = 1'b1;
            end
            ENTER: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                int_inject  = 1'b1;
            end
            default: ;
        endcase

        if (luh) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b1;
            int_inject   = 1'b0;
        end

        if (ex_branch_taken) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            id_ex_bubble = 1'b0;
            int_inject   = 1'b0;
        end

        // Everything is held quiet while reset is asserted.
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            id_ex_bubble = 1'b0;
            int_inject   = 1'b0;
        end
    end

    // Interrupt-entry next-state logic and pending/ack bookkeeping.
    always_comb begin
        state_next     = state_reg;
        irq_pend_next  = irq_pend_reg;
        drain_cnt_next = drain_cnt_reg;
        irq_ack_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                // Edges arriving during DRAIN/ENTER are dropped, not queued.
                if (irq_rise)
                    irq_pend_next = 1'b1;
                // A hazarded instruction finishes its stall before draining starts.
                if (irq_pend_reg && !luh) begin
                    state_next     = DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                // Counter keeps running even across a taken branch.
                if (drain_cnt_reg == 4'd0)
                    state_next = ENTER;
                else
                    drain_cnt_next = drain_cnt_reg - 4'd1;
            end
            ENTER: begin
                // Injection only counts when it actually reached ID/EX; a branch
                // or bubble suppresses it, so ENTER is repeated.
                if (!ex_branch_taken && !luh) begin
                    state_next    = IDLE;
                    irq_pend_next = 1'b0;
                    irq_ack_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM and interrupt bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            irq_pend_reg  <= 1'b0;
            irq_q_reg     <= 1'b0;
            drain_cnt_reg <= 4'd0;
            irq_ack_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            irq_pend_reg  <= irq_pend_next;
            irq_q_reg     <= irq;
            drain_cnt_reg <= drain_cnt_next;
            irq_ack_reg   <= irq_ack_next;
        end
    end

    // Saturating count of cycles in which the PC was frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count_reg <= '0;
        else if (!pc_write && (stall_count_reg != {CNT_W{1'b1}}))
            stall_count_reg <= stall_count_reg + 1'b1;
    end

    assign irq_ack     = irq_ack_reg;
    assign stall_count = stall_count_reg;

endmodule
